// File: rtl/e203_clk_gate_mgr.sv
`default_nettype none
// ============================================================================
// Module   : e203_clk_gate_mgr (+ e203_clkgate cell)
// Purpose  : Per-channel clock gating with idle hysteresis, light-sleep
//            request and per-channel WFI masking.
// Revision : 1.0
// ============================================================================

module e203_clkgate (
    input  logic clk_in,
    input  logic test_mode,
    input  logic clock_en,
    output logic clk_out
);
    logic en_lat;

    // Enable is captured while the clock is low so clk_out never glitches.
    always_latch begin
        if (!clk_in) begin
            en_lat = clock_en | test_mode;
        end
    end

    assign clk_out = clk_in & en_lat;
endmodule

module e203_clk_gate_mgr #(
    parameter int                CH_NUM   = 4,
    parameter int                HOLD_CYC = 2,
    parameter int                LS_CYC   = 8,
    parameter int                CNT_W    = 4,
    parameter logic [CH_NUM-1:0] WFI_MASK = CH_NUM'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              test_mode,
    input  logic              core_cgstop,
    input  logic              core_wfi,
    input  logic [CH_NUM-1:0] ch_active,
    output logic [CH_NUM-1:0] clk_ch,
    output logic [CH_NUM-1:0] ch_ls,
    output logic [CH_NUM-1:0] ch_gated,
    output logic              clk_aon
);
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HOLD  = 2'd1,
        S_GATE  = 2'd2,
        S_SLEEP = 2'd3
    } state_t;

    // Terminal counts; HOLD_LAST is unused when HOLD_CYC is zero.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LS_LAST   = CNT_W'(LS_CYC - 1);

    assign clk_aon = clk;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             req;
        logic             clk_en;

        assign req = core_cgstop | (ch_active[i] & ~(core_wfi & WFI_MASK[i]));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= S_RUN;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                S_RUN: begin
                    if (!req) begin
                        state_nxt = (HOLD_CYC == 0) ? S_GATE : S_HOLD;
                        cnt_nxt   = '0;
                    end
                end
                S_HOLD: begin
                    if (req) begin
                        state_nxt = S_RUN;
                    end else if (cnt == HOLD_LAST) begin
                        state_nxt = S_GATE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_GATE: begin
                    if (req) begin
                        state_nxt = S_RUN;
                    end else if (cnt == LS_LAST) begin
                        state_nxt = S_SLEEP;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_SLEEP: begin
                    if (req) begin
                        state_nxt = S_RUN;
                    end
                end
                default: state_nxt = S_RUN;
            endcase
        end

        // req term gives zero-latency wake through the gate latch.
        assign clk_en      = req | (state == S_RUN) | (state == S_HOLD);
        assign ch_ls[i]    = ~test_mode & (state == S_SLEEP) & ~req;
        assign ch_gated[i] = (state == S_GATE) | (state == S_SLEEP);

        e203_clkgate u_clkgate (
            .clk_in    (clk),
            .test_mode (test_mode),
            .clock_en  (clk_en),
            .clk_out   (clk_ch[i])
        );
    end
endmodule

`default_nettype wire

// File: tb/tb_e203_clk_gate_mgr.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_clk_gate_mgr
// Purpose  : Directed scoreboard bench for the clock-gating manager.
// Revision : 1.0
// ============================================================================

module tb_e203_clk_gate_mgr;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       test_mode = 1'b0;
    logic       core_cgstop = 1'b0;
    logic       core_wfi = 1'b0;
    logic [3:0] ch_active = 4'hF;
    logic [3:0] clk_ch;
    logic [3:0] ch_ls;
    logic [3:0] ch_gated;
    logic       clk_aon;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // ph=0: sampled 1 time unit after posedge number cyc (clk high, so a
    // high clk_ch means that edge was delivered); ph=1: 1 unit after the
    // following negedge.
    typedef struct {
        int       cyc;
        bit       ph;
        bit [3:0] mask;
        bit [3:0] clk_e;
        bit [3:0] ls_e;
        bit [3:0] gated_e;
        string    name;
    } exp_t;

    exp_t sb[$];

    e203_clk_gate_mgr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .test_mode   (test_mode),
        .core_cgstop (core_cgstop),
        .core_wfi    (core_wfi),
        .ch_active   (ch_active),
        .clk_ch      (clk_ch),
        .ch_ls       (ch_ls),
        .ch_gated    (ch_gated),
        .clk_aon     (clk_aon)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input bit ph, input bit [3:0] mask,
                             input bit [3:0] ce, input bit [3:0] le,
                             input bit [3:0] ge, input string name);
        exp_t e;
        e.cyc = c; e.ph = ph; e.mask = mask;
        e.clk_e = ce; e.ls_e = le; e.gated_e = ge; e.name = name;
        sb.push_back(e);
    endtask

    task automatic goto(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic check_phase(input bit ph);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc && sb[i].ph == ph) begin
                checks++;
                if (((clk_ch ^ sb[i].clk_e) & sb[i].mask) != 4'h0 ||
                    ((ch_ls ^ sb[i].ls_e) & sb[i].mask) != 4'h0 ||
                    ((ch_gated ^ sb[i].gated_e) & sb[i].mask) != 4'h0 ||
                    clk_aon != clk) begin
                    failures++;
                    $display("FAIL %s cyc=%0d ph=%0d mask=%h: clk_ch=%h ls=%h gated=%h aon=%b, expected clk_ch=%h ls=%h gated=%h aon=%b",
                             sb[i].name, cyc, ph, sb[i].mask, clk_ch, ch_ls, ch_gated,
                             clk_aon, sb[i].clk_e, sb[i].ls_e, sb[i].gated_e, clk);
                end
                sb.delete(i);
            end
        end
    endtask

    // Monitor: compares whatever expectations fall due at each sample point.
    initial begin
        forever begin
            @(posedge clk); #1; check_phase(1'b0);
            @(negedge clk); #1; check_phase(1'b1);
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        for (int c = 1; c <= 3; c++) expect_at(c, 0, 4'hF, 4'hF, 4'h0, 4'h0, "reset_run");
        goto(3);
        rst_n = 1'b1;
        for (int c = 4; c <= 6; c++) expect_at(c, 0, 4'hF, 4'hF, 4'h0, 4'h0, "post_reset_run");

        // Channel 1 idles from cycle 6: three more edges, then gated, sleep after 8 gated cycles.
        goto(6);
        ch_active[1] = 1'b0;
        expect_at(7,  0, 4'h2, 4'h2, 4'h0, 4'h0, "ch1_hold_a");
        expect_at(8,  0, 4'h2, 4'h2, 4'h0, 4'h0, "ch1_hold_b");
        expect_at(9,  0, 4'h2, 4'h2, 4'h0, 4'h2, "ch1_last_edge");
        expect_at(10, 0, 4'hF, 4'hD, 4'h0, 4'h2, "ch1_first_gated");
        expect_at(16, 0, 4'h2, 4'h0, 4'h0, 4'h2, "ch1_pre_ls");
        expect_at(17, 0, 4'h2, 4'h0, 4'h2, 4'h2, "ch1_ls_on");
        expect_at(25, 0, 4'h2, 4'h0, 4'h2, 4'h2, "ch1_sleep_hold");
        goto(26);
        ch_active[1] = 1'b1;
        expect_at(26, 1, 4'h2, 4'h0, 4'h0, 4'h2, "ch1_ls_comb_drop");
        expect_at(27, 0, 4'h2, 4'h2, 4'h0, 4'h0, "ch1_wake_edge");

        // WFI masks channel 0 only; cgstop restores it on the next edge.
        goto(30);
        core_wfi = 1'b1;
        expect_at(33, 0, 4'hF, 4'hF, 4'h0, 4'h1, "wfi_ch0_gating");
        expect_at(34, 0, 4'hF, 4'hE, 4'h0, 4'h1, "wfi_ch0_gated");
        goto(36);
        core_cgstop = 1'b1;
        expect_at(36, 1, 4'hF, 4'h0, 4'h0, 4'h1, "cgstop_pre_edge");
        expect_at(37, 0, 4'hF, 4'hF, 4'h0, 4'h0, "cgstop_restore");
        goto(38);
        core_cgstop = 1'b0;
        core_wfi    = 1'b0;

        // Idle runs shorter than the hold window never gate channel 2.
        for (int k = 0; k < 10; k++) begin
            goto(40 + k);
            ch_active[2] = (k % 2 == 0);
            expect_at(41 + k, 0, 4'h4, 4'h4, 4'h0, 4'h0, "ch2_pulse_never_gated");
        end
        goto(50);
        ch_active[2] = 1'b1;

        // Channel 3 to sleep, then asynchronous reset mid-cycle.
        goto(52);
        ch_active[3] = 1'b0;
        goto(65);
        expect_at(65, 1, 4'h8, 4'h0, 4'h8, 4'h8, "ch3_sleeping");
        expect_at(66, 0, 4'h8, 4'h0, 4'h8, 4'h8, "ch3_sleep_edge");
        expect_at(66, 1, 4'h8, 4'h0, 4'h0, 4'h0, "ch3_async_reset");
        @(posedge clk);
        #3 rst_n = 1'b0;
        goto(66);
        ch_active = 4'hF;
        expect_at(67, 0, 4'hF, 4'hF, 4'h0, 4'h0, "in_reset_run");
        expect_at(68, 0, 4'hF, 4'hF, 4'h0, 4'h0, "in_reset_run");
        goto(68);
        rst_n = 1'b1;
        expect_at(69, 0, 4'hF, 4'hF, 4'h0, 4'h0, "after_reset_run");
        expect_at(70, 0, 4'hF, 4'hF, 4'h0, 4'h0, "after_reset_run");

        // Test mode: clocks free-run, ls forced low, gated status still reported.
        goto(72);
        test_mode = 1'b1;
        ch_active = 4'h0;
        for (int k = 1; k <= 20; k++)
            expect_at(72 + k, 0, 4'hF, 4'hF, 4'h0, (k >= 3) ? 4'hF : 4'h0, "test_mode_free_run");
        goto(92);
        test_mode = 1'b0;
        ch_active = 4'hF;
        expect_at(92, 1, 4'hF, 4'h0, 4'h0, 4'hF, "exit_test_mode_pre");
        expect_at(93, 0, 4'hF, 4'hF, 4'h0, 4'h0, "exit_test_mode_wake");

        goto(96);
        while (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL unchecked_%s due cyc=%0d: actual never sampled, required sampled", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: actual still running, required finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
